// File: rtl/traffic_light_ctrl_pkg.sv
// Shared definitions for the pedestrian-crossing sequencer: state encodings,
// lamp-vector bit positions and the state-to-lamp decode.
package traffic_light_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_GREEN = 3'd0;
  localparam state_t S_AMBER = 3'd1;
  localparam state_t S_RED_A = 3'd2;
  localparam state_t S_WALK  = 3'd3;
  localparam state_t S_FLASH = 3'd4;
  localparam state_t S_RED_B = 3'd5;

  localparam int unsigned LAMP_CAR_RED   = 0;
  localparam int unsigned LAMP_CAR_AMBER = 1;
  localparam int unsigned LAMP_CAR_GREEN = 2;
  localparam int unsigned LAMP_PED_RED   = 3;
  localparam int unsigned LAMP_PED_GREEN = 4;
  localparam int unsigned LAMP_W         = 5;

  typedef logic [LAMP_W-1:0] lamp_t;

  // Exactly one car lamp and at most one ped lamp per state; unknown codes show all-red.
  function automatic lamp_t lamp_decode(input state_t state, input logic blink);
    lamp_t lamps;
    lamps = '0;
    case (state)
      S_GREEN: begin
        lamps[LAMP_CAR_GREEN] = 1'b1;
        lamps[LAMP_PED_RED]   = 1'b1;
      end
      S_AMBER: begin
        lamps[LAMP_CAR_AMBER] = 1'b1;
        lamps[LAMP_PED_RED]   = 1'b1;
      end
      S_WALK: begin
        lamps[LAMP_CAR_RED]   = 1'b1;
        lamps[LAMP_PED_GREEN] = 1'b1;
      end
      S_FLASH: begin
        lamps[LAMP_CAR_RED]   = 1'b1;
        lamps[LAMP_PED_GREEN] = blink;
      end
      default: begin
        lamps[LAMP_CAR_RED]   = 1'b1;
        lamps[LAMP_PED_RED]   = 1'b1;
      end
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a one-clock
// rising-edge pulse. Reusable for any push-button input.
module traffic_light_ctrl_btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_din,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Pedestrian-crossing light sequencer driven by the divider's tick strobe.
// Serves a latched walk request once the minimum car-green time has elapsed.
module traffic_light_ctrl
  import traffic_light_ctrl_pkg::*;
#(
  parameter int unsigned CW          = 8,
  parameter int unsigned T_GREEN_MIN = 20,
  parameter int unsigned T_AMBER     = 12,
  parameter int unsigned T_ALLRED    = 4,
  parameter int unsigned T_WALK      = 28,
  parameter int unsigned T_FLASH     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_ped_req,
  output logic o_car_red,
  output logic o_car_amber,
  output logic o_car_green,
  output logic o_ped_red,
  output logic o_ped_green,
  output logic o_req_lamp
);

  localparam logic [CW-1:0] L_GREEN_LAST  = CW'(T_GREEN_MIN - 1);
  localparam logic [CW-1:0] L_AMBER_LAST  = CW'(T_AMBER - 1);
  localparam logic [CW-1:0] L_ALLRED_LAST = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] L_WALK_LAST   = CW'(T_WALK - 1);
  localparam logic [CW-1:0] L_FLASH_LAST  = CW'(T_FLASH - 1);

  state_t        r_state;
  state_t        w_state_d;
  state_t        w_next;
  logic [CW-1:0] r_dwell;
  logic [CW-1:0] w_dwell_d;
  logic          r_pending;
  logic          w_pending_d;
  logic          r_blink;
  logic          w_blink_d;
  lamp_t         r_lamps;
  logic          r_req_lamp;
  logic          w_ped_pulse;
  logic          w_legal;
  logic          w_green_sat;

  traffic_light_ctrl_btn_sync_edge u_ped_sync (
    .clk     (clk),
    .reset   (reset),
    .i_din   (i_ped_req),
    .o_pulse (w_ped_pulse)
  );

  assign w_legal     = (r_state <= S_RED_B);
  assign w_green_sat = (r_state == S_GREEN) && (r_dwell >= L_GREEN_LAST);

  // Candidate successor, only acted upon on a tick cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_GREEN: if (r_pending && w_green_sat)      w_next = S_AMBER;
      S_AMBER: if (r_dwell == L_AMBER_LAST)       w_next = S_RED_A;
      S_RED_A: if (r_dwell == L_ALLRED_LAST)      w_next = S_WALK;
      S_WALK:  if (r_dwell == L_WALK_LAST)        w_next = S_FLASH;
      S_FLASH: if (r_dwell == L_FLASH_LAST)       w_next = S_RED_B;
      S_RED_B: if (r_dwell == L_ALLRED_LAST)      w_next = S_GREEN;
      default:                                    w_next = S_RED_B;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_dwell_d = r_dwell;
    if (!w_legal) begin
      // Corrupted state register recovers without waiting for a tick.
      w_state_d = S_RED_B;
      w_dwell_d = '0;
    end else if (i_tick) begin
      if (w_next != r_state) begin
        w_state_d = w_next;
        w_dwell_d = '0;
      end else if (!w_green_sat) begin
        w_dwell_d = r_dwell + CW'(1);
      end
    end
  end

  // A new press in the same clock as entry to WALK takes priority over the clear.
  always_comb begin
    w_pending_d = r_pending;
    if ((w_state_d == S_WALK) && (r_state != S_WALK)) w_pending_d = 1'b0;
    if (w_ped_pulse)                                  w_pending_d = 1'b1;
  end

  always_comb begin
    if (w_state_d != S_FLASH)     w_blink_d = 1'b0;
    else if (r_state != S_FLASH)  w_blink_d = 1'b1;
    else if (i_tick)              w_blink_d = ~r_blink;
    else                          w_blink_d = r_blink;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_RED_B;
      r_dwell    <= '0;
      r_pending  <= 1'b0;
      r_blink    <= 1'b0;
      r_lamps    <= lamp_decode(S_RED_B, 1'b0);
      r_req_lamp <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_dwell    <= w_dwell_d;
      r_pending  <= w_pending_d;
      r_blink    <= w_blink_d;
      r_lamps    <= lamp_decode(w_state_d, w_blink_d);
      r_req_lamp <= w_pending_d;
    end
  end

  assign o_car_red   = r_lamps[LAMP_CAR_RED];
  assign o_car_amber = r_lamps[LAMP_CAR_AMBER];
  assign o_car_green = r_lamps[LAMP_CAR_GREEN];
  assign o_ped_red   = r_lamps[LAMP_PED_RED];
  assign o_ped_green = r_lamps[LAMP_PED_GREEN];
  assign o_req_lamp  = r_req_lamp;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with short dwell times and a tick
// every few clocks; lamp vector compared against hand-derived values.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic tick;
  logic ped_req;
  logic car_red, car_amber, car_green, ped_red, ped_green, req_lamp;

  int n_checks = 0;
  int n_errors = 0;

  // {car_red, car_amber, car_green, ped_red, ped_green, req_lamp}
  localparam logic [5:0] V_GREEN = 6'b001100;
  localparam logic [5:0] V_AMBER = 6'b010100;
  localparam logic [5:0] V_RED   = 6'b100100;
  localparam logic [5:0] V_WALK  = 6'b100010;
  localparam logic [5:0] V_FLOFF = 6'b100000;

  logic [5:0] lamps;
  assign lamps = {car_red, car_amber, car_green, ped_red, ped_green, req_lamp};

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .CW          (8),
    .T_GREEN_MIN (4),
    .T_AMBER     (2),
    .T_ALLRED    (1),
    .T_WALK      (3),
    .T_FLASH     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_tick      (tick),
    .i_ped_req   (ped_req),
    .o_car_red   (car_red),
    .o_car_amber (car_amber),
    .o_car_green (car_green),
    .o_ped_red   (ped_red),
    .o_ped_green (ped_green),
    .o_req_lamp  (req_lamp)
  );

  task automatic check(input string tag, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(4);
    end
  endtask

  // Press, confirm the three-clock latency to req_lamp, then release.
  task automatic press(input string tag);
    ped_req = 1'b1;
    step(2);
    check({tag, "_req_early"}, {5'b0, req_lamp}, 6'd0);
    step(1);
    check({tag, "_req_set"}, {5'b0, req_lamp}, 6'd1);
    ped_req = 1'b0;
    step(1);
  endtask

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    ped_req = 1'b0;
    step(3);
    check("rst_lamps", lamps, V_RED);
    reset = 1'b0;
    step(2);
    check("redb_no_tick", lamps, V_RED);
    tick_n(1);
    check("t1_green", lamps, V_GREEN);
    tick_n(10);
    check("t1_green_stay", lamps, V_GREEN);

    // Long green: request is served on the very next tick.
    press("t3");
    tick_n(1);
    check("t3_amber", lamps, V_AMBER | 6'd1);
    tick_n(1);
    check("t3_amber_hold", lamps, V_AMBER | 6'd1);
    tick_n(1);
    check("t3_red_a", lamps, V_RED | 6'd1);
    tick_n(1);
    check("t3_walk", lamps, V_WALK);

    // Presses during WALK and FLASH collapse into one extra cycle.
    press("t4");
    tick_n(2);
    check("t4_walk_hold", lamps, V_WALK | 6'd1);
    tick_n(1);
    check("t4_flash_on", lamps, V_WALK | 6'd1);
    ped_req = 1'b1;
    tick_n(1);
    check("t4_flash_off", lamps, V_FLOFF | 6'd1);
    tick_n(1);
    check("t4_red_b", lamps, V_RED | 6'd1);
    tick_n(1);
    check("t4_green", lamps, V_GREEN | 6'd1);
    tick_n(3);
    check("t4_min_green", lamps, V_GREEN | 6'd1);
    tick_n(1);
    check("t4_amber", lamps, V_AMBER | 6'd1);
    tick_n(2);
    check("t4_red_a", lamps, V_RED | 6'd1);
    tick_n(1);
    check("t4_walk_clear", lamps, V_WALK);
    ped_req = 1'b0;
    tick_n(3);
    check("t4_flash2", lamps, V_WALK);
    tick_n(2);
    check("t4_red_b2", lamps, V_RED);
    tick_n(1);
    check("t4_green2", lamps, V_GREEN);
    tick_n(8);
    check("t4_no_third", lamps, V_GREEN);

    // Consecutive tick clocks each count as a tick.
    press("t6");
    tick_n(1);
    check("t6_amber", lamps, V_AMBER | 6'd1);
    tick = 1'b1;
    step(1);
    check("t6_tick1", lamps, V_AMBER | 6'd1);
    step(1);
    check("t6_tick2", lamps, V_RED | 6'd1);
    step(1);
    check("t6_tick3", lamps, V_WALK);
    tick = 1'b0;
    step(4);

    // Asynchronous reset in WALK.
    #3;
    reset = 1'b1;
    #1;
    check("t5_async_rst", lamps, V_RED);
    step(2);
    reset = 1'b0;
    step(3);
    check("t5_red_b", lamps, V_RED);
    tick_n(1);
    check("t5_green", lamps, V_GREEN);

    // Press at first green tick: minimum green still enforced.
    tick_n(1);
    press("t2");
    tick_n(2);
    check("t2_green_min", lamps, V_GREEN | 6'd1);
    tick_n(1);
    check("t2_amber", lamps, V_AMBER | 6'd1);
    tick_n(2);
    check("t2_red_a", lamps, V_RED | 6'd1);

    // New request lands in the same clock as entry to WALK and survives.
    ped_req = 1'b1;
    step(2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check("walk_entry_req_wins", lamps, V_WALK | 6'd1);
    ped_req = 1'b0;
    step(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
